vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder_if.sv | 26 ++
 rtl/vga_sync_decoder.sv | 183 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync stream into the decoder and recovered timing back out.
interface vga_sync_decoder_if;
   logic       i_HSync;
   logic       i_VSync;
   logic       o_HSync;
   logic       o_VSync;
   logic [9:0] o_Col_Count;
   logic [9:0] o_Row_Count;
   logic       o_Locked;
   logic       o_Frame_Start;
   logic       o_Err;

   // Sync source side
   modport master (
      output i_HSync, i_VSync,
      input  o_HSync, o_VSync, o_Col_Count, o_Row_Count,
      input  o_Locked, o_Frame_Start, o_Err
   );

   // Decoder side
   modport slave (
      input  i_HSync, i_VSync,
      output o_HSync, o_VSync, o_Col_Count, o_Row_Count,
      output o_Locked, o_Frame_Start, o_Err
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers column/row position from H/V sync edges, checks line and frame
// timing against the nominal geometry and tracks lock.
module vga_sync_decoder #(
   parameter int unsigned TOTAL_COLS  = 800,
   parameter int unsigned TOTAL_ROWS  = 525,
   parameter int unsigned ACTIVE_COLS = 640,
   parameter int unsigned ACTIVE_ROWS = 480,
   parameter int unsigned LOCK_LINES  = 4,
   parameter int unsigned ERR_LIMIT   = 3
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   vga_sync_decoder_if.slave bus
);
   localparam int unsigned   CW        = 10;
   localparam int unsigned   GW        = $clog2(LOCK_LINES + 1);
   localparam int unsigned   EW        = $clog2(ERR_LIMIT + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(TOTAL_COLS - 1);
   localparam logic [CW-1:0] ROW_LAST  = CW'(TOTAL_ROWS - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_ALIGN  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   // Reject geometries the 10-bit counters or the active window cannot represent
   if (ACTIVE_COLS > TOTAL_COLS || ACTIVE_ROWS > TOTAL_ROWS ||
       TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_geometry
      $error("vga_sync_decoder: inconsistent geometry parameters");
   end

   logic          h1, h2, v1, v2;
   logic [1:0]    state, state_nxt;
   logic [CW-1:0] col, col_nxt;
   logic [CW-1:0] row, row_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic [EW-1:0] err_cnt, errc_nxt;
   logic          locked, locked_nxt;
   logic          frame_start, fs_nxt;
   logic          err, err_nxt;

   logic h_edge, v_edge, col_last, frame_last;
   logic line_good, line_bad, frame_good, frame_bad;

   assign h_edge     = h1 & ~h2;
   assign v_edge     = v1 & ~v2;
   assign col_last   = (col == COL_LAST);
   assign frame_last = col_last && (row == ROW_LAST);
   // A line is bad when the edge and the expected wrap point disagree
   assign line_good  = h_edge && col_last;
   assign line_bad   = h_edge ^ col_last;
   assign frame_good = v_edge && frame_last;
   assign frame_bad  = v_edge ^ frame_last;

   // Two-stage input pipeline; outputs and counts are aligned to stage two
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         h1 <= 1'b0;
         h2 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         h1 <= bus.i_HSync;
         h2 <= h1;
         v1 <= bus.i_VSync;
         v2 <= v1;
      end
   end

   // State, counters and registered status outputs
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= S_SEARCH;
         col         <= '0;
         row         <= '0;
         good_cnt    <= '0;
         err_cnt     <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         col         <= col_nxt;
         row         <= row_nxt;
         good_cnt    <= good_nxt;
         err_cnt     <= errc_nxt;
         locked      <= locked_nxt;
         frame_start <= fs_nxt;
         err         <= err_nxt;
      end
   end

   // Next-state, count update and status pulses
   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      good_nxt  = good_cnt;
      errc_nxt  = err_cnt;
      fs_nxt    = 1'b0;
      err_nxt   = 1'b0;

      // Free-running position with edge resync; else-if prevents a double row step
      if (v_edge) begin
         col_nxt = '0;
         row_nxt = '0;
      end else if (h_edge || col_last) begin
         col_nxt = '0;
         row_nxt = (row == ROW_LAST) ? '0 : row + CW'(1);
      end else begin
         col_nxt = col + CW'(1);
      end

      case (state)
         S_SEARCH: begin
            col_nxt = '0;
            row_nxt = '0;
            if (v_edge) begin
               state_nxt = S_ALIGN;
               fs_nxt    = 1'b1;
               good_nxt  = '0;
            end
         end

         S_ALIGN: begin
            if (line_bad || frame_bad) begin
               err_nxt   = 1'b1;
               state_nxt = S_SEARCH;
               good_nxt  = '0;
               col_nxt   = '0;
               row_nxt   = '0;
            end else begin
               fs_nxt = frame_good;
               if (line_good) begin
                  if (good_cnt == GOOD_LAST) begin
                     state_nxt = S_LOCKED;
                     good_nxt  = '0;
                     errc_nxt  = '0;
                  end else begin
                     good_nxt = good_cnt + GW'(1);
                  end
               end
            end
         end

         S_LOCKED: begin
            fs_nxt = frame_good;
            if (line_bad || frame_bad) begin
               err_nxt = 1'b1;
               if (err_cnt == ERR_LAST) begin
                  state_nxt = S_SEARCH;
                  errc_nxt  = '0;
                  col_nxt   = '0;
                  row_nxt   = '0;
               end else begin
                  errc_nxt = err_cnt + EW'(1);
               end
            end else if (line_good) begin
               errc_nxt = '0;
            end
         end

         default: begin
            state_nxt = S_SEARCH;
            col_nxt   = '0;
            row_nxt   = '0;
            good_nxt  = '0;
            errc_nxt  = '0;
         end
      endcase

      locked_nxt = (state_nxt == S_LOCKED);
   end

   assign bus.o_HSync       = h2;
   assign bus.o_VSync       = v2;
   assign bus.o_Col_Count   = col;
   assign bus.o_Row_Count   = row;
   assign bus.o_Locked      = locked;
   assign bus.o_Frame_Start = frame_start;
   assign bus.o_Err         = err;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 32x12 raster.
module tb_vga_sync_decoder;
   localparam int COLS  = 32;
   localparam int ROWS  = 12;
   localparam int ACT_C = 24;
   localparam int ACT_R = 9;
   localparam int FRAME = COLS * ROWS;

   logic clk = 1'b0;
   logic rst;
   int   tests_run = 0;
   int   tests_failed = 0;

   // g_*: next position to drive; d_*: position just driven; e_*: what outputs show now
   int   g_col, g_row, d_col, d_row, e_col, e_row;
   logic d_hs, d_vs, e_hs, e_vs;
   int   hgap_row = -1, hgap_lo = 0, hgap_hi = 0;
   int   hkill_lo = -1, hkill_hi = -1;
   int   vgap_row = -1;

   vga_sync_decoder_if bus ();

   vga_sync_decoder #(
      .TOTAL_COLS (COLS),
      .TOTAL_ROWS (ROWS),
      .ACTIVE_COLS(ACT_C),
      .ACTIVE_ROWS(ACT_R),
      .LOCK_LINES (4),
      .ERR_LIMIT  (3)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic gen_hs(input int r, input int c);
      return (c < ACT_C) && !(r == hgap_row && c >= hgap_lo && c <= hgap_hi)
             && !(r >= hkill_lo && r <= hkill_hi);
   endfunction

   // Drive one raster position, clock it, sample 1 time unit after the edge
   task automatic step();
      logic hs, vs;
      hs = gen_hs(g_row, g_col);
      vs = (g_row < ACT_R) && (g_row != vgap_row);
      bus.i_HSync = hs;
      bus.i_VSync = vs;
      @(posedge clk);
      #1;
      e_col = d_col; e_row = d_row; e_hs = d_hs; e_vs = d_vs;
      d_col = g_col; d_row = g_row; d_hs = hs; d_vs = vs;
      if (g_col == COLS - 1) begin
         g_col = 0;
         g_row = (g_row == ROWS - 1) ? 0 : g_row + 1;
      end else begin
         g_col = g_col + 1;
      end
   endtask

   // Advance until the outputs represent raster position (r,c)
   task automatic run_to(input int r, input int c);
      for (int i = 0; i < FRAME + 2; i++) begin
         step();
         if (e_row == r && e_col == c) break;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      tests_run++;
      if ({bus.o_HSync, bus.o_VSync, bus.o_Col_Count, bus.o_Row_Count,
           bus.o_Locked, bus.o_Frame_Start, bus.o_Err} !== 25'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got col=%0d row=%0d lk=%b fs=%b err=%b hs=%b vs=%b want all 0",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Locked, bus.o_Frame_Start, bus.o_Err,
                  bus.o_HSync, bus.o_VSync);
      end
      rst = 1'b0;
   endtask

   task automatic test_acquire();
      run_to(ROWS - 1, COLS - 1);
      tests_run++;
      if (bus.o_Locked !== 1'b0 || bus.o_Frame_Start !== 1'b0 ||
          bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0) begin
         tests_failed++;
         $display("FAIL search_idle: got lk=%b fs=%b col=%0d row=%0d want 0 0 0 0",
                  bus.o_Locked, bus.o_Frame_Start, bus.o_Col_Count, bus.o_Row_Count);
      end
      step();
      tests_run++;
      if (bus.o_Frame_Start !== 1'b1 || bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0) begin
         tests_failed++;
         $display("FAIL first_frame_start: got fs=%b col=%0d row=%0d want 1 0 0",
                  bus.o_Frame_Start, bus.o_Col_Count, bus.o_Row_Count);
      end
      step();
      tests_run++;
      if (bus.o_Frame_Start !== 1'b0 || bus.o_Col_Count !== 10'd1) begin
         tests_failed++;
         $display("FAIL frame_start_pulse: got fs=%b col=%0d want 0 1", bus.o_Frame_Start, bus.o_Col_Count);
      end
      run_to(3, COLS - 1);
      tests_run++;
      if (bus.o_Locked !== 1'b0 || bus.o_Col_Count !== 10'(COLS - 1) || bus.o_Row_Count !== 10'd3) begin
         tests_failed++;
         $display("FAIL align_before_lock: got lk=%b col=%0d row=%0d want 0 %0d 3",
                  bus.o_Locked, bus.o_Col_Count, bus.o_Row_Count, COLS - 1);
      end
      step();
      tests_run++;
      if (bus.o_Locked !== 1'b1 || bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd4) begin
         tests_failed++;
         $display("FAIL lock_after_4_lines: got lk=%b col=%0d row=%0d want 1 0 4",
                  bus.o_Locked, bus.o_Col_Count, bus.o_Row_Count);
      end
   endtask

   // Clean stream: outputs equal the generator two clocks late, no errors
   task automatic test_track(input int frames);
      int bad, fr, fc, gr, gc;
      bad = 0; fr = 0; fc = 0; gr = 0; gc = 0;
      for (int i = 0; i < frames * FRAME; i++) begin
         step();
         if (bus.o_Col_Count !== 10'(e_col) || bus.o_Row_Count !== 10'(e_row) ||
             bus.o_HSync !== e_hs || bus.o_VSync !== e_vs || bus.o_Locked !== 1'b1 ||
             bus.o_Err !== 1'b0 || bus.o_Frame_Start !== ((e_col == 0 && e_row == 0) ? 1'b1 : 1'b0)) begin
            if (bad == 0) begin
               fr = e_row; fc = e_col; gr = int'(bus.o_Row_Count); gc = int'(bus.o_Col_Count);
            end
            bad++;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL track: %0d bad cycles, first got row=%0d col=%0d want row=%0d col=%0d",
                  bad, gr, gc, fr, fc);
      end
   endtask

   task automatic test_wrap_corner();
      run_to(ROWS - 1, COLS - 1);
      tests_run++;
      if (bus.o_Col_Count !== 10'(COLS - 1) || bus.o_Row_Count !== 10'(ROWS - 1) || bus.o_Frame_Start !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_last: got col=%0d row=%0d fs=%b want %0d %0d 0",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Frame_Start, COLS - 1, ROWS - 1);
      end
      step();
      tests_run++;
      if (bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0 ||
          bus.o_Frame_Start !== 1'b1 || bus.o_Err !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_zero: got col=%0d row=%0d fs=%b err=%b want 0 0 1 0",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Frame_Start, bus.o_Err);
      end
   endtask

   task automatic test_early_hsync();
      hgap_row = 6; hgap_lo = 12; hgap_hi = 15;
      run_to(6, 15);
      tests_run++;
      if (bus.o_Col_Count !== 10'd15 || bus.o_Row_Count !== 10'd6 || bus.o_Err !== 1'b0) begin
         tests_failed++;
         $display("FAIL early_before: got col=%0d row=%0d err=%b want 15 6 0",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Err);
      end
      step();
      tests_run++;
      if (bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd7 ||
          bus.o_Err !== 1'b1 || bus.o_Locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL early_resync: got col=%0d row=%0d err=%b lk=%b want 0 7 1 1",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Err, bus.o_Locked);
      end
      step();
      tests_run++;
      if (bus.o_Err !== 1'b0 || bus.o_Col_Count !== 10'd1) begin
         tests_failed++;
         $display("FAIL early_single_pulse: got err=%b col=%0d want 0 1", bus.o_Err, bus.o_Col_Count);
      end
      hgap_row = -1;
      run_to(0, 0);
      run_to(2, 0);
      tests_run++;
      if (bus.o_Locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL early_keeps_lock: got lk=%b want 1", bus.o_Locked);
      end
      test_track(1);
   endtask

   task automatic test_loss_of_lock();
      int bad;
      bad = 0;
      run_to(1, 0);
      hkill_lo = 3; hkill_hi = 5;
      run_to(3, 0);
      tests_run++;
      if (bus.o_Err !== 1'b1 || bus.o_Locked !== 1'b1 || bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd3) begin
         tests_failed++;
         $display("FAIL miss_1: got err=%b lk=%b col=%0d row=%0d want 1 1 0 3",
                  bus.o_Err, bus.o_Locked, bus.o_Col_Count, bus.o_Row_Count);
      end
      run_to(4, 0);
      tests_run++;
      if (bus.o_Err !== 1'b1 || bus.o_Locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL miss_2: got err=%b lk=%b want 1 1", bus.o_Err, bus.o_Locked);
      end
      run_to(5, 0);
      tests_run++;
      if (bus.o_Err !== 1'b1 || bus.o_Locked !== 1'b0 || bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0) begin
         tests_failed++;
         $display("FAIL miss_3_unlock: got err=%b lk=%b col=%0d row=%0d want 1 0 0 0",
                  bus.o_Err, bus.o_Locked, bus.o_Col_Count, bus.o_Row_Count);
      end
      for (int i = 0; i < FRAME && !(e_row == ROWS - 1 && e_col == COLS - 1); i++) begin
         step();
         if (bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0 || bus.o_Locked !== 1'b0 ||
             bus.o_Err !== 1'b0 || bus.o_Frame_Start !== 1'b0) bad++;
      end
      hkill_lo = -1; hkill_hi = -1;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL search_hold: got %0d non-idle cycles want 0", bad);
      end
      step();
      tests_run++;
      if (bus.o_Frame_Start !== 1'b1 || bus.o_Locked !== 1'b0) begin
         tests_failed++;
         $display("FAIL reacquire_fs: got fs=%b lk=%b want 1 0", bus.o_Frame_Start, bus.o_Locked);
      end
      run_to(4, 0);
      tests_run++;
      if (bus.o_Locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL relock: got lk=%b want 1", bus.o_Locked);
      end
      test_track(1);
   endtask

   task automatic test_misplaced_vsync();
      run_to(1, 0);
      vgap_row = 4;
      run_to(5, 0);
      vgap_row = -1;
      tests_run++;
      if (bus.o_Err !== 1'b1 || bus.o_Frame_Start !== 1'b0 || bus.o_Col_Count !== 10'd0 ||
          bus.o_Row_Count !== 10'd0 || bus.o_Locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL misplaced_vs: got err=%b fs=%b col=%0d row=%0d lk=%b want 1 0 0 0 1",
                  bus.o_Err, bus.o_Frame_Start, bus.o_Col_Count, bus.o_Row_Count, bus.o_Locked);
      end
      step();
      tests_run++;
      if (bus.o_Err !== 1'b0 || bus.o_Col_Count !== 10'd1 || bus.o_Row_Count !== 10'd0) begin
         tests_failed++;
         $display("FAIL misplaced_after: got err=%b col=%0d row=%0d want 0 1 0",
                  bus.o_Err, bus.o_Col_Count, bus.o_Row_Count);
      end
      run_to(0, 0);
      run_to(1, 0);
      test_track(1);
   endtask

   task automatic test_async_reset();
      run_to(7, 10);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.o_HSync, bus.o_VSync, bus.o_Col_Count, bus.o_Row_Count,
           bus.o_Locked, bus.o_Frame_Start, bus.o_Err} !== 25'd0) begin
         tests_failed++;
         $display("FAIL async_reset_now: got col=%0d row=%0d lk=%b hs=%b vs=%b want all 0",
                  bus.o_Col_Count, bus.o_Row_Count, bus.o_Locked, bus.o_HSync, bus.o_VSync);
      end
      run_to(10, 20);
      rst = 1'b0;
      run_to(ROWS - 1, COLS - 1);
      tests_run++;
      if (bus.o_Locked !== 1'b0 || bus.o_Col_Count !== 10'd0 || bus.o_Row_Count !== 10'd0) begin
         tests_failed++;
         $display("FAIL post_reset_search: got lk=%b col=%0d row=%0d want 0 0 0",
                  bus.o_Locked, bus.o_Col_Count, bus.o_Row_Count);
      end
      step();
      tests_run++;
      if (bus.o_Frame_Start !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_fs: got fs=%b want 1", bus.o_Frame_Start);
      end
      run_to(3, COLS - 1);
      tests_run++;
      if (bus.o_Locked !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_align: got lk=%b want 0", bus.o_Locked);
      end
      step();
      tests_run++;
      if (bus.o_Locked !== 1'b1 || bus.o_Row_Count !== 10'd4) begin
         tests_failed++;
         $display("FAIL post_reset_relock: got lk=%b row=%0d want 1 4", bus.o_Locked, bus.o_Row_Count);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_HSync = 1'b0;
      bus.i_VSync = 1'b0;
      g_row = 10; g_col = 5;
      d_row = 0;  d_col = 0; d_hs = 1'b0; d_vs = 1'b0;
      e_row = 0;  e_col = 0; e_hs = 1'b0; e_vs = 1'b0;
      test_reset();
      test_acquire();
      test_track(2);
      test_wrap_corner();
      test_early_hsync();
      test_loss_of_lock();
      test_misplaced_vsync();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
